// File: rtl/canvas_pkg.sv
// Shared constants and types for the 32x24 canvas front end and grid.
package canvas_pkg;
  localparam int unsigned NX = 32;
  localparam int unsigned NY = 24;
  localparam int unsigned CW = 5;

  typedef enum logic {IDLE, SWEEP} canvas_state_t;
  typedef logic [CW-1:0] coord_t;
endpackage

// File: rtl/canvas_controller_if.sv
// Button-event inputs and grid-facing outputs of canvas_controller.
interface canvas_controller_if;
  import canvas_pkg::*;

  logic   move_up;
  logic   move_down;
  logic   move_left;
  logic   move_right;
  logic   draw;
  logic   erase;
  logic   clear_req;
  coord_t cursor_x;
  coord_t cursor_y;
  logic   button1;
  logic   button2;
  logic   busy;
  logic   sweep_done;

  modport master (
    output move_up, move_down, move_left, move_right, draw, erase, clear_req,
    input  cursor_x, cursor_y, button1, button2, busy, sweep_done
  );

  modport slave (
    input  move_up, move_down, move_left, move_right, draw, erase, clear_req,
    output cursor_x, cursor_y, button1, button2, busy, sweep_done
  );
endinterface

// File: rtl/canvas_controller_cursor_step.sv
// One-axis cursor step; wraps at the edges when CANVAS_CURSOR_WRAP_EN is defined,
// otherwise saturates at the edge pixel.
module cursor_step #(
  parameter int unsigned CW = 5
) (
  input  logic          inc,
  input  logic          dec,
  input  logic [CW-1:0] pos,
  input  logic [CW:0]   limit,
  output logic [CW-1:0] pos_next
);
`ifdef CANVAS_CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [CW:0] pos_ext;
  logic [CW:0] last;

  always_comb begin
    pos_ext  = {1'b0, pos};
    last     = limit - (CW+1)'(1);
    pos_next = pos;
    if (inc && !dec) begin
      if (pos_ext == last) pos_next = WRAP ? '0 : pos;
      else                 pos_next = pos + 1'b1;
    end else if (dec && !inc) begin
      if (pos == '0) pos_next = WRAP ? last[CW-1:0] : pos;
      else           pos_next = pos - 1'b1;
    end
  end
endmodule

// File: rtl/canvas_controller.sv
// Cursor/draw sequencer for the canvas grid with a full-canvas clear sweep.
// Edge behaviour of the cursor is selected by CANVAS_CURSOR_WRAP_EN (see cursor_step).
module canvas_controller #(
  parameter int unsigned NX = canvas_pkg::NX,
  parameter int unsigned NY = canvas_pkg::NY,
  parameter int unsigned CW = canvas_pkg::CW
) (
  input  logic                clock,
  input  logic                rst_n,
  canvas_controller_if.slave  bus
);
  import canvas_pkg::*;

  localparam logic [CW-1:0] X_LAST = CW'(NX - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(NY - 1);

  canvas_state_t state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] sav_x_q, sav_x_d, sav_y_q, sav_y_d;
  logic          b1_q, b1_d, b2_q, b2_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [CW-1:0] step_x, step_y;

  cursor_step #(.CW(CW)) u_step_x (
    .inc      (bus.move_right),
    .dec      (bus.move_left),
    .pos      (x_q),
    .limit    ((CW+1)'(NX)),
    .pos_next (step_x)
  );

  cursor_step #(.CW(CW)) u_step_y (
    .inc      (bus.move_down),
    .dec      (bus.move_up),
    .pos      (y_q),
    .limit    ((CW+1)'(NY)),
    .pos_next (step_y)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sav_x_d = sav_x_q;
    sav_y_d = sav_y_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = SWEEP;
          sav_x_d = x_q;
          sav_y_d = y_q;
          x_d     = '0;
          y_d     = '0;
          b1_d    = 1'b0;
          b2_d    = 1'b1;
          busy_d  = 1'b1;
        end else begin
          x_d  = step_x;
          y_d  = step_y;
          b1_d = bus.draw;
          b2_d = bus.erase & ~bus.draw;
        end
      end
      SWEEP: begin
        // Last pixel is erased on this edge; hand the grid back to the user path.
        if (x_q == X_LAST && y_q == Y_LAST) begin
          state_d = IDLE;
          x_d     = sav_x_q;
          y_d     = sav_y_q;
          b2_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (x_q == X_LAST) begin
          x_d = '0;
          y_d = y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sav_x_q <= '0;
      sav_y_q <= '0;
      b1_q    <= 1'b0;
      b2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sav_x_q <= sav_x_d;
      sav_y_q <= sav_y_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.cursor_x   = x_q;
  assign bus.cursor_y   = y_q;
  assign bus.button1    = b1_q;
  assign bus.button2    = b2_q;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = done_q;
endmodule

// File: doc/canvas_controller.md
# canvas_controller

Sequencing front end for the 32×24 pixel grid. Turns debounced user button events into the grid's shared cursor coordinates and draw/erase strobes. Adds a hardware "clear canvas" sweep that takes over the grid inputs and erases every pixel. Sits between the button debouncers and the grid, and arbitrates grid access between the user path and the sweep engine.

## Interface
Parameters:
- NX, 32, grid width in pixels
- NY, 24, grid height in pixels
- CW, 5, coordinate width; must satisfy 2^CW ≥ max(NX, NY)

Ports:
- clock  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- move_up  in  1  single-cycle pulse, y − 1
- move_down  in  1  single-cycle pulse, y + 1
- move_left  in  1  single-cycle pulse, x − 1
- move_right  in  1  single-cycle pulse, x + 1
- draw  in  1  level, paint pixel under cursor
- erase  in  1  level, clear pixel under cursor
- clear_req  in  1  single-cycle pulse, start full-canvas clear
- cursor_x  out  CW  grid column driven to grid
- cursor_y  out  CW  grid row driven to grid
- button1  out  1  grid set strobe
- button2  out  1  grid clear strobe
- busy  out  1  sweep in progress; user inputs ignored
- sweep_done  out  1  one-cycle pulse at sweep completion

## Operation
- One clock; reset is asynchronous and active-low (clock port `clock`, reset port `rst_n`).
- All outputs are registered. Reset values: cursor_x=0, cursor_y=0, button1=0, button2=0, busy=0, sweep_done=0, state=IDLE, saved cursor=(0,0).
- States: IDLE and SWEEP.
- IDLE, per edge:
  - x steps by move_right − move_left. Both asserted means no x change.
  - y steps by move_down − move_up. Both asserted means no y change.
  - x and y update independently in the same cycle.
  - Boundaries (x=0 going left, x=NX−1 going right, y=0 going up, y=NY−1 going down) follow the Configuration section.
  - button1 ← draw.
  - button2 ← erase & ~draw. Draw wins when both are asserted.
- IDLE → SWEEP on clear_req:
  - Save current cursor.
  - Drive cursor=(0,0), button1=0, button2=1, busy=1.
  - Moves, draw and erase arriving in the same cycle are discarded.
- SWEEP, per edge:
  - x increments. At x=NX−1, x wraps to 0 and y increments.
  - button2 stays 1.
  - All user inputs are ignored, including clear_req.
- SWEEP → IDLE on the edge where cursor is (NX−1, NY−1):
  - Restore the saved cursor.
  - Drive button2=0, busy=0, sweep_done=1 for exactly one cycle.
- Reset mid-sweep: immediate return to IDLE with reset values. The saved cursor is lost and the grid is left partially cleared.

## Timing
- Move latency: a move pulse sampled at edge k gives the new cursor valid after edge k. The grid writes on edge k+1.
- Draw/erase latency: one cycle. Draw sampled at edge k together with a move paints the new position on edge k+1.
- Clear latency: clear_req at edge k gives busy=1 after edge k.
  - Pixel (0,0) is cleared at edge k+1.
  - Each coordinate is held exactly one cycle.
  - Sweep lasts NX·NY = 768 cycles.
  - Edge k+768 drops busy and pulses sweep_done; the cursor is restored after that edge.
- Back-to-back clear_req pulses: only the first one counts. A clear_req on the cycle sweep_done is high is accepted as a new sweep.

## Configuration
- CANVAS_CURSOR_WRAP_EN defined: the cursor wraps at the edges.
  - Left at x=0 → NX−1; right at NX−1 → 0.
  - Up at y=0 → NY−1; down at NY−1 → 0.
- Undefined (default): the cursor saturates and stays at the edge pixel.
- The sweep is unaffected in both cases.

## Structure
- Package `canvas_pkg` holds:
  - NX, NY, CW constants shared with the grid.
  - `canvas_state_t` enum {IDLE, SWEEP}.
  - `coord_t` typedef (logic [CW−1:0]).
- Sub-module `cursor_step`: combinational one-axis step, with inputs inc, dec, pos and limit, producing the next pos with wrap/clamp.
  - Instantiated twice (x with limit NX, y with limit NY).
  - Selects its boundary behaviour from the macro.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle → all outputs 0 immediately. Release, then 3 move_right and 2 move_down pulses → cursor=(3,2).
- Draw priority: draw=1 and erase=1 at cursor (5,5) → next cycle button1=1, button2=0. Drop draw → button2=1.
- Boundary: at (0,0) pulse move_left and move_up.
  - Without macro → (0,0).
  - With CANVAS_CURSOR_WRAP_EN → (31,23).
  - move_left and move_right together → x unchanged.
- Full clear: paint (4,7) and (31,23), park at (10,10), pulse clear_req.
  - busy high exactly 768 cycles; button2=1 throughout.
  - Cursor visits (0,0)…(31,23) row-major.
  - sweep_done one-cycle pulse; cursor returns to (10,10); all 768 grid bits 0.
- Sweep lockout: during sweep, pulse moves, draw and clear_req → sweep sequence unchanged, no second sweep, restored cursor still (10,10).
- Reset mid-sweep: assert rst_n at sweep cycle 300 → IDLE, cursor (0,0), busy=0, no sweep_done. Pixels beyond index 299 keep their prior values.
